router_port_arbiter: RTL and testbench

- Round-robin arbiter for a single router output port; one instance per output port.
- Shares the port among NUM_REQ input ports whose decoded destination address selects it.
- Holds a grant for a whole packet and releases on end-of-packet, abort or hold timeout.
- Drives the per-port busy_n seen by the inputs and the select for the output mux.

---
 rtl/router_port_arbiter.sv | 167 ++++++++++++++++
 tb/tb_router_port_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_port_arbiter.sv
// router_port_arbiter
//   Round-robin arbiter owning one router output port. Requesting inputs
//   (active-low req_n) compete for the port; the winner keeps it for a whole
//   packet and gives it up on its end-of-packet strobe, on dropping its
//   request (abort), or when the hold limit MAX_HOLD expires (0 = no limit).
//   Every release spends exactly one RELEASE cycle with the port free before
//   the next grant, and the round-robin pointer then moves to the last winner.
//
// Parameters
//   NUM_REQ   number of requesting input ports
//   IDX_W     width of grant_idx (2**IDX_W >= NUM_REQ)
//   MAX_HOLD  maximum grant length in cycles; 0 disables the hold timeout
//
// Ports
//   clock          rising-edge clock
//   reset_n        asynchronous active-low reset (release synchronised upstream)
//   req_n          active-low request per input
//   eop_n          active-low end-of-packet strobe per input (granted input only)
//   grant_n        active-low one-hot grant
//   grant_idx      index of the current / most recent winner
//   busy_n         low while the port is owned
//   timeout        one-cycle pulse in the RELEASE cycle after a hold timeout
//   grant_count    (ROUTER_ARB_STATS_EN) grants since reset, saturating
//   timeout_count  (ROUTER_ARB_STATS_EN) timeouts since reset, saturating
//
// Build option
//   ROUTER_ARB_STATS_EN  adds the grant_count / timeout_count statistics ports.

module router_port_arbiter #(
  parameter int NUM_REQ  = 16,
  parameter int IDX_W    = 4,
  parameter int MAX_HOLD = 1024
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req_n,
  input  logic [NUM_REQ-1:0] eop_n,
  output logic [NUM_REQ-1:0] grant_n,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               busy_n,
  output logic               timeout
`ifdef ROUTER_ARB_STATS_EN
  ,
  output logic [15:0]        grant_count,
  output logic [7:0]         timeout_count
`endif
);

  localparam int CNT_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  state_t             state;
  logic [IDX_W-1:0]   ptr;
  logic [CNT_W-1:0]   hold_cnt;

  // First requester strictly after base, wrapping modulo NUM_REQ. The
  // distance (i - base - 1) mod NUM_REQ ranks candidates; smallest wins.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req_v,
                                               input logic [IDX_W-1:0]   base);
    logic [IDX_W-1:0] win;
    int               best;
    int               d;
    win  = '0;
    best = NUM_REQ;
    for (int i = 0; i < NUM_REQ; i++) begin
      d = (i + NUM_REQ - int'(base) - 1) % NUM_REQ;
      if (req_v[i] && (d < best)) begin
        best = d;
        win  = IDX_W'(i);
      end
    end
    return win;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot_n(input logic [IDX_W-1:0] idx);
    return ~(NUM_REQ'(1) << idx);
  endfunction

  logic [NUM_REQ-1:0] req;
  logic               any_req;
  logic [IDX_W-1:0]   arb_base;
  logic [IDX_W-1:0]   winner;
  logic               eop_hit;
  logic               abort_hit;
  logic               hold_hit;

  assign req       = ~req_n;
  assign any_req   = |req;
  // In RELEASE the pointer is being moved to grant_idx this very cycle, so
  // arbitrate from grant_idx directly rather than the stale pointer.
  assign arb_base  = (state == RELEASE) ? grant_idx : ptr;
  assign winner    = rr_pick(req, arb_base);
  assign eop_hit   = ~eop_n[grant_idx];
  assign abort_hit = req_n[grant_idx];
  assign hold_hit  = (MAX_HOLD != 0) && (hold_cnt == CNT_W'(MAX_HOLD));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      grant_n   <= '1;
      grant_idx <= '0;
      busy_n    <= 1'b1;
      timeout   <= 1'b0;
      hold_cnt  <= '0;
      ptr       <= IDX_W'(NUM_REQ - 1);
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE, RELEASE: begin
          if (state == RELEASE) ptr <= grant_idx;
          if (any_req) begin
            state     <= GRANT;
            grant_idx <= winner;
            grant_n   <= onehot_n(winner);
            busy_n    <= 1'b0;
            hold_cnt  <= CNT_W'(1);
          end else begin
            state     <= IDLE;
            hold_cnt  <= '0;
          end
        end
        GRANT: begin
          if (eop_hit || abort_hit || hold_hit) begin
            state    <= RELEASE;
            grant_n  <= '1;
            busy_n   <= 1'b1;
            hold_cnt <= '0;
            // eop and abort take precedence: a timeout coinciding with
            // either is a normal release, not a revoked grant.
            timeout  <= hold_hit && !eop_hit && !abort_hit;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ROUTER_ARB_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // A grant is issued exactly when IDLE/RELEASE sees any request.
  logic grant_start;
  assign grant_start = (state != GRANT) && any_req;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      grant_count   <= '0;
      timeout_count <= '0;
    end else begin
      if (grant_start) grant_count   <= sat_inc16(grant_count);
      if (timeout)     timeout_count <= sat_inc8(timeout_count);
    end
  end
`else
  // Statistics disabled: no counter state and no statistics ports.
`endif

endmodule

// File: tb/tb_router_port_arbiter.sv
// Scoreboard bench for router_port_arbiter. Two instances: dut (MAX_HOLD
// 1024) for the packet, fairness, abort and reset scenarios, and dut8
// (MAX_HOLD 8) for hold-timeout and statistics scenarios. Stimulus pushes
// expected grant/release events; a negedge monitor pops and compares them
// whenever busy_n changes.

module tb_router_port_arbiter;

  logic        clock   = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] req_n     [2];
  logic [15:0] eop_n     [2];
  logic [15:0] grant_n   [2];
  logic [3:0]  grant_idx [2];
  logic        busy_n    [2];
  logic        timeout   [2];
`ifdef ROUTER_ARB_STATS_EN
  logic [15:0] grant_count   [2];
  logic [7:0]  timeout_count [2];
`endif

  router_port_arbiter #(.NUM_REQ(16), .IDX_W(4), .MAX_HOLD(1024)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req_n     (req_n[0]),
    .eop_n     (eop_n[0]),
    .grant_n   (grant_n[0]),
    .grant_idx (grant_idx[0]),
    .busy_n    (busy_n[0]),
    .timeout   (timeout[0])
`ifdef ROUTER_ARB_STATS_EN
    ,
    .grant_count   (grant_count[0]),
    .timeout_count (timeout_count[0])
`endif
  );

  router_port_arbiter #(.NUM_REQ(16), .IDX_W(4), .MAX_HOLD(8)) dut8 (
    .clock     (clock),
    .reset_n   (reset_n),
    .req_n     (req_n[1]),
    .eop_n     (eop_n[1]),
    .grant_n   (grant_n[1]),
    .grant_idx (grant_idx[1]),
    .busy_n    (busy_n[1]),
    .timeout   (timeout[1])
`ifdef ROUTER_ARB_STATS_EN
    ,
    .grant_count   (grant_count[1]),
    .timeout_count (timeout_count[1])
`endif
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  typedef struct {
    bit is_grant;
    int idx;
    int cyc;
    bit to;
  } ev_t;

  ev_t  exp_q [2][$];
  logic busy_prev [2];
  int   compared = 0;
  int   failed   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic void push_ev(input int i, input bit g, input int idx, input int c, input bit to);
    ev_t e;
    e.is_grant = g;
    e.idx      = idx;
    e.cyc      = c;
    e.to       = to;
    exp_q[i].push_back(e);
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Monitor: every busy_n edge is a grant (falling) or release (rising).
  always @(negedge clock) begin : mon
    ev_t         e;
    logic [15:0] oh;
    for (int i = 0; i < 2; i++) begin
      if (busy_n[i] !== busy_prev[i]) begin
        if (exp_q[i].size() == 0) begin
          compared++;
          failed++;
          $display("FAIL unexpected_event inst%0d at cycle %0d: busy_n got %b, expected %b",
                   i, cyc, busy_n[i], busy_prev[i]);
        end else begin
          e = exp_q[i].pop_front();
          chk($sformatf("kind_inst%0d", i), 32'(busy_n[i] == 1'b0), 32'(e.is_grant));
          chk($sformatf("event_cycle_inst%0d", i), cyc, e.cyc);
          chk($sformatf("grant_idx_inst%0d", i), 32'(grant_idx[i]), e.idx);
          if (e.is_grant) begin
            oh        = 16'hFFFF;
            oh[e.idx] = 1'b0;
            chk($sformatf("grant_n_inst%0d", i), 32'(grant_n[i]), 32'(oh));
          end else begin
            chk($sformatf("release_grant_n_inst%0d", i), 32'(grant_n[i]), 32'hFFFF);
            chk($sformatf("timeout_inst%0d", i), 32'(timeout[i]), 32'(e.to));
          end
        end
      end
      busy_prev[i] = busy_n[i];
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    int t;
    int v;
    busy_prev[0] = 1'b1;
    busy_prev[1] = 1'b1;
    req_n[0] = '1; req_n[1] = '1;
    eop_n[0] = '1; eop_n[1] = '1;

    // Reset state
    wait_cyc(2);
    chk("rst_grant_n", 32'(grant_n[0]), 32'hFFFF);
    chk("rst_busy_n", 32'(busy_n[0]), 32'h1);
    chk("rst_grant_idx", 32'(grant_idx[0]), 32'h0);
    chk("rst_timeout", 32'(timeout[0]), 32'h0);
    chk("rst_busy_n_dut8", 32'(busy_n[1]), 32'h1);
    @(negedge clock);
    reset_n = 1'b1;
    wait_cyc(2);

    // Single requester 0, eop at cycle 10 after request, regrant
    req_n[0] = 16'hFFFE;
    push_ev(0, 1, 0, cyc + 1, 0);
    wait_cyc(10);
    eop_n[0][0] = 1'b0;
    push_ev(0, 0, 0, cyc + 1, 0);
    push_ev(0, 1, 0, cyc + 2, 0);
    wait_cyc(1);
    eop_n[0] = '1;
    wait_cyc(1);
    req_n[0] = '1;
    push_ev(0, 0, 0, cyc + 1, 0);
    wait_cyc(3);

    // Pointer back to 15 so input 0 leads the fairness round
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    wait_cyc(1);

    // All 16 requesting, eop 5 cycles after each grant: 0..15,0
    req_n[0] = '0;
    g = cyc + 1;
    push_ev(0, 1, 0, g, 0);
    for (int k = 0; k <= 16; k++) begin
      wait_cyc(g + 5 - cyc);
      eop_n[0] = ~(16'h1 << (k % 16));
      if (k == 16) req_n[0] = '1;
      push_ev(0, 0, k % 16, g + 6, 0);
      if (k < 16) push_ev(0, 1, (k + 1) % 16, g + 7, 0);
      wait_cyc(1);
      eop_n[0] = '1;
      g += 7;
    end
    wait_cyc(2);

    // Input 5 aborts while 9 waits: release without timeout, then 9
    req_n[0][5] = 1'b0;
    push_ev(0, 1, 5, cyc + 1, 0);
    wait_cyc(2);
    req_n[0][9] = 1'b0;
    wait_cyc(2);
    req_n[0][5] = 1'b1;
    push_ev(0, 0, 5, cyc + 1, 0);
    push_ev(0, 1, 9, cyc + 2, 0);
    wait_cyc(3);
    eop_n[0][9] = 1'b0;
    req_n[0][9] = 1'b1;
    push_ev(0, 0, 9, cyc + 1, 0);
    wait_cyc(1);
    eop_n[0] = '1;
    wait_cyc(2);

    // Input 7 granted, eop from requesting input 2 ignored, then reset
    req_n[0][7] = 1'b0;
    push_ev(0, 1, 7, cyc + 1, 0);
    wait_cyc(2);
    req_n[0][2] = 1'b0;
    req_n[0][4] = 1'b0;
    wait_cyc(1);
    eop_n[0][2] = 1'b0;
    wait_cyc(1);
    eop_n[0] = '1;
    wait_cyc(2);
    chk("foreign_eop_busy_n", 32'(busy_n[0]), 32'h0);
    chk("foreign_eop_grant_idx", 32'(grant_idx[0]), 32'd7);
    #2;
    push_ev(0, 0, 0, cyc, 0);
    reset_n = 1'b0;
    #1;
    chk("async_rst_grant_n", 32'(grant_n[0]), 32'hFFFF);
    chk("async_rst_busy_n", 32'(busy_n[0]), 32'h1);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    push_ev(0, 1, 2, cyc + 1, 0);
    wait_cyc(2);
    req_n[0] = '1;
    push_ev(0, 0, 2, cyc + 1, 0);
    wait_cyc(3);

    // dut8: input 3 held with no eop -> 8-cycle grant, timeout, regrant
    t = cyc;
    req_n[1][3] = 1'b0;
    push_ev(1, 1, 3, t + 1, 0);
    push_ev(1, 0, 3, t + 9, 1);
    push_ev(1, 1, 3, t + 10, 0);
    wait_cyc(10);
    chk("timeout_single_cycle", 32'(timeout[1]), 32'h0);
    wait_cyc(2);
    eop_n[1][3] = 1'b0;
    req_n[1][3] = 1'b1;
    push_ev(1, 0, 3, cyc + 1, 0);
    wait_cyc(1);
    eop_n[1] = '1;
    wait_cyc(2);

    // dut8: short packet on input 1
    req_n[1][1] = 1'b0;
    push_ev(1, 1, 1, cyc + 1, 0);
    wait_cyc(3);
    eop_n[1][1] = 1'b0;
    req_n[1][1] = 1'b1;
    push_ev(1, 0, 1, cyc + 1, 0);
    wait_cyc(1);
    eop_n[1] = '1;
    wait_cyc(2);

    // dut8: eop on input 6 exactly when the hold limit hits -> no timeout
    v = cyc;
    req_n[1][6] = 1'b0;
    push_ev(1, 1, 6, v + 1, 0);
    wait_cyc(8);
    eop_n[1][6] = 1'b0;
    req_n[1][6] = 1'b1;
    push_ev(1, 0, 6, v + 9, 0);
    wait_cyc(1);
    eop_n[1] = '1;
    wait_cyc(3);

`ifdef ROUTER_ARB_STATS_EN
    chk("grant_count", 32'(grant_count[1]), 32'd4);
    chk("timeout_count", 32'(timeout_count[1]), 32'd1);
`endif

    chk("pending_events_dut", exp_q[0].size(), 0);
    chk("pending_events_dut8", exp_q[1].size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
